// File: rtl/dual_slope_sequencer.sv
// dual_slope_sequencer: dual-slope ADC phase sequencer with autorange, fault flags and latched result
module dual_slope_sequencer #(
    parameter int CNT_W    = 16,
    parameter int RANGE_W  = 3,
    parameter int N_RANGES = 5,
    parameter int T_RST    = 16,
    parameter int T_INT    = 1000,
    parameter int UNDER_TH = 100
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         mode_sel_i,
    input  logic               start_i,
    input  logic [RANGE_W-1:0] range_i,
    input  logic               comp_i,
    input  logic               sat_hi_i,
    input  logic               sat_lo_i,
    input  logic               ref_ok_i,
    input  logic               irq_clr_i,
    output logic [1:0]         afe_sel_o,
    output logic [RANGE_W-1:0] range_sel_o,
    output logic               afe_reset_o,
    output logic               ref_sign_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   result_o,
    output logic               result_sign_o,
    output logic [RANGE_W-1:0] result_range_o,
    output logic               result_valid_o,
    output logic               range_error_o,
    output logic               ref_error_o,
    output logic               irq_o
);
    typedef enum logic [2:0] {IDLE, ZERO, INTEG, DEINT, DONE} state_t;

    localparam logic [CNT_W-1:0]   TMO = CNT_W'(2 * T_INT);
    localparam logic [RANGE_W-1:0] TOP = RANGE_W'(N_RANGES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, meas;
    logic [1:0]       mode_q;
    logic             sat, last_int, go, ref_fail, up, ovr, flip, tmo;

    assign sat      = sat_hi_i | sat_lo_i;
    assign last_int = cnt == CNT_W'(T_INT - 1);

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // next state, phase events and AFE controls
    always_comb begin
        state_n  = state;
        go       = 1'b0;
        ref_fail = 1'b0;
        up       = 1'b0;
        ovr      = 1'b0;
        flip     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                go       = start_i && mode_sel_i != 2'b00 && ref_ok_i;
                ref_fail = start_i && !ref_ok_i;
                state_n  = go ? ZERO : IDLE;
            end
            ZERO:  state_n = cnt == CNT_W'(T_RST - 1) ? INTEG : ZERO;
            INTEG: begin
                up      = sat && mode_q == 2'b11 && range_sel_o < TOP;
                ovr     = sat && !up;
                state_n = up ? ZERO : ovr ? DONE : last_int ? DEINT : INTEG;
            end
            DEINT: begin
                flip    = comp_i != ref_sign_o;
                tmo     = !flip && cnt == TMO;
                state_n = (flip || tmo) ? DONE : DEINT;
            end
            DONE:    state_n = mode_sel_i[1] ? ZERO : IDLE;
            default: state_n = IDLE;
        endcase
        // losing the reference anywhere in the measurement aborts without a result
        if (state inside {ZERO, INTEG, DEINT} && !ref_ok_i) begin
            state_n  = IDLE;
            ref_fail = 1'b1;
            up       = 1'b0;
            ovr      = 1'b0;
            flip     = 1'b0;
            tmo      = 1'b0;
        end
        afe_reset_o = state == IDLE || state == ZERO;
        afe_sel_o   = state == ZERO ? 2'b11 : state == INTEG ? 2'b01 : state == DEINT ? 2'b10 : 2'b00;
        busy_o      = state != IDLE;
    end

    // phase counter restarts on every state change and saturates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                cnt <= '0;
        else if (state_n != state) cnt <= '0;
        else if (!(&cnt))         cnt <= cnt + 1'b1;
    end

    // range, sign, measurement, published result and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q         <= '0;
            range_sel_o    <= '0;
            ref_sign_o     <= 1'b0;
            meas           <= '0;
            result_o       <= '0;
            result_sign_o  <= 1'b0;
            result_range_o <= '0;
            result_valid_o <= 1'b0;
            range_error_o  <= 1'b0;
            ref_error_o    <= 1'b0;
            irq_o          <= 1'b0;
        end else begin
            if (go) begin
                mode_q <= mode_sel_i;
                if (mode_sel_i != 2'b11) range_sel_o <= range_i > TOP ? TOP : range_i;
            end
            if (up) range_sel_o <= range_sel_o + 1'b1;
            if (state == INTEG && state_n == DEINT) ref_sign_o <= comp_i;
            if (ovr)  meas <= '1;
            if (flip) meas <= cnt;
            if (tmo)  meas <= TMO;
            if (state == DONE) begin
                result_o       <= meas;
                result_sign_o  <= ref_sign_o;
                result_range_o <= range_sel_o;
                mode_q         <= mode_sel_i;
                if (mode_q == 2'b11 && meas < CNT_W'(UNDER_TH) && range_sel_o != '0)
                    range_sel_o <= range_sel_o - 1'b1;
            end
            result_valid_o <= state == DONE;
            range_error_o  <= (range_error_o & ~irq_clr_i) | ovr | tmo;
            ref_error_o    <= (ref_error_o & ~irq_clr_i) | ref_fail;
            irq_o          <= (irq_o & ~irq_clr_i) | ovr | tmo | ref_fail | (state == DONE);
        end
    end
endmodule

// File: doc/dual_slope_sequencer.md
# dual_slope_sequencer

Parametrised dual-slope conversion sequencer for the voltmeter digital core; it generalises the current state-machine-plus-counter pair. It sits between the analog sanitizer outputs and the SPI/register layer. It drives the AFE through the reset, integrate and de-integrate phases and measures de-integration time with an internal counter. It adds continuous conversion, optional autoranging, reference and timeout fault detection, and a latched result with an interrupt.

## Interface
- `CNT_W`, 16: result/counter width.
- `RANGE_W`, 3: range select width.
- `N_RANGES`, 5: number of valid ranges, 0..N_RANGES-1; 0 is the most sensitive.
- `T_RST`, 16: integrator reset phase length, in cycles.
- `T_INT`, 1000: integrate phase length, in cycles; must satisfy 2*T_INT < 2^CNT_W.
- `UNDER_TH`, 100: a de-integrate count below this is underrange, used for autorange down-stepping.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mode_sel_i` in 2: 00 stop, 01 single, 10 continuous manual-range, 11 continuous autorange.
- `start_i` in 1: start pulse; only sampled in IDLE.
- `range_i` in RANGE_W: manual range, latched at start.
- `comp_i`, `sat_hi_i`, `sat_lo_i`, `ref_ok_i` in 1 each: sanitized AFE status.
- `irq_clr_i` in 1: clears `irq_o`, `range_error_o` and `ref_error_o`.
- `afe_sel_o` out 2: 00 hold, 01 input, 10 reference, 11 zero.
- `range_sel_o` out RANGE_W: active range.
- `afe_reset_o` out 1: integrator short.
- `ref_sign_o` out 1: reference polarity for de-integration.
- `busy_o` out 1: high in any state other than IDLE.
- `result_o` out CNT_W: last de-integrate count.
- `result_sign_o` out 1: input polarity, 1 = positive.
- `result_range_o` out RANGE_W: range used for the result.
- `result_valid_o` out 1: one-cycle pulse when a new result is latched.
- `range_error_o`, `ref_error_o` out 1 each: sticky fault flags.
- `irq_o` out 1: sticky; set on every `result_valid_o` or fault.

## Operation
- **Reset values:** state IDLE; all outputs 0 except `afe_reset_o` = 1.
- **States:** IDLE, ZERO, INTEG, DEINT, DONE.
- **IDLE:** `afe_reset_o` = 1, `afe_sel_o` = 00.
  - Leaves IDLE on `start_i`=1 with mode ≠ 00 and `ref_ok_i`=1.
  - On entry to ZERO: `range_sel_o` ← `range_i`, clamped to N_RANGES-1. In mode 11 the range keeps its previous autorange value instead.
  - `start_i` with `ref_ok_i`=0: `ref_error_o` and `irq_o` set, stay in IDLE.
- **ZERO:** `afe_reset_o` = 1, `afe_sel_o` = 11, for exactly T_RST cycles, then INTEG.
- **INTEG:** `afe_reset_o` = 0, `afe_sel_o` = 01, for exactly T_INT cycles.
  - `sat_hi_i` or `sat_lo_i` during INTEG is overrange.
    - Mode 11 with range < N_RANGES-1: range+1, back to ZERO, no result.
    - Otherwise: `range_error_o` set, `result_o` = all ones, go to DONE.
  - On the last INTEG cycle: sign ← `comp_i`, and `ref_sign_o` ← `comp_i`.
- **DEINT:** `afe_sel_o` = 10; the counter increments every cycle from 0.
  - Ends on the first cycle where `comp_i` ≠ latched sign; `result_o` = count at that cycle.
  - Timeout: count reaches 2*T_INT → `range_error_o` set, `result_o` = 2*T_INT.
- **DONE:** one cycle.
  - Latches `result_o`, `result_sign_o`, `result_range_o`; pulses `result_valid_o`; sets `irq_o`.
  - Next state: mode 10/11 → ZERO; mode 01/00 → IDLE.
  - In mode 11, if result < UNDER_TH and range > 0, range−1 for the next conversion. The result is still published.
- **Reference loss:** `ref_ok_i`=0 in ZERO, INTEG or DEINT aborts to IDLE. `ref_error_o` and `irq_o` set; no result.
- **Mode changes:** only take effect at DONE. Mode 00 mid-conversion finishes the current conversion, then goes to IDLE.
- **Error flags:** sticky until `irq_clr_i`. If `irq_clr_i` and a set event occur in the same cycle, set wins.
- **Counter:** saturating at CNT_W.

## Timing
- `start_i` sampled in cycle 0 → ZERO in cycles 1..T_RST → INTEG in cycles T_RST+1..T_RST+T_INT → DEINT starts in cycle T_RST+T_INT+1.
- DEINT termination detected in cycle k → DONE in cycle k+1. `result_valid_o` and updated result registers are visible in cycle k+2 (registered outputs).
- `busy_o` falls the cycle after DONE in single mode.
- In continuous mode, back-to-back conversions are separated by exactly one DONE cycle.
- `rst_i` mid-conversion returns all outputs to reset values immediately (asynchronous); results are lost.

## Test plan
- **Single conversion:** T_RST=16, T_INT=1000, mode 01, `comp_i`=1 during INTEG, `comp_i` drops 437 cycles into DEINT → `result_o`=437, `result_sign_o`=1, `ref_sign_o`=1, one `result_valid_o` pulse, `irq_o`=1, `busy_o` low afterward.
- **Autorange up:** mode 11, range 0, `sat_hi_i` pulse in INTEG on ranges 0 and 1 → `range_sel_o` steps 0→1→2; first result has `result_range_o`=2, no error.
- **Overrange at top:** range 4 with saturation → `range_error_o`=1, `result_o`=16'hFFFF, `result_valid_o` pulses.
- **DEINT timeout:** `comp_i` never flips → `result_o`=2000, `range_error_o`=1. `irq_clr_i` then clears both `irq_o` and `range_error_o`.
- **Reference loss and reset:** `ref_ok_i`=0 mid-INTEG → IDLE, `ref_error_o`=1, no `result_valid_o`. `rst_i` pulse during DEINT → `afe_reset_o`=1 and all other outputs 0 in the same cycle.
- **Continuous with down-step:** mode 11, result 50 (< UNDER_TH) on range 2 → result published, next conversion on range 1. Mode set to 00 mid-DEINT → finishes, then goes to IDLE.
